// File: rtl/dsc_mul_sched_pkg.sv
// dsc_pkg: shared constants and types for the stochastic-multiplier scheduler.
//   SNG_WIDTH_DEFAULT : default operand width W
//   RUN_LEN_W         : run counter width (2W+1) for the default W
//   state_e           : scheduler FSM state encoding
//   run_len_w()       : run counter width for an arbitrary W
package dsc_pkg;

    localparam int SNG_WIDTH_DEFAULT = 4;

    // b*2^W can reach (2^W-1)*2^W, which needs 2W bits; one spare bit keeps
    // the counter comfortably above the largest run length.
    function automatic int run_len_w(input int w);
        return 2 * w + 1;
    endfunction

    localparam int RUN_LEN_W = run_len_w(SNG_WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/dsc_mul_sched_if.sv
// Request/result bus of the multiplier scheduler.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_a/req_b         : packed operands, [W-1:0] requester 0, [2W-1:W] requester 1
//   res_valid/res_ready : result handshake
//   res_z/res_id        : product and owning requester
// master = requesters/result consumer, slave = scheduler.
interface dsc_mul_sched_if #(
    parameter int W = 4
) ();
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_z;
    logic           res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_z, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_z, res_id
    );
endinterface

// File: rtl/dsc_mul_sched_rr_arb_2.sv
// rr_arb_2: two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   adv        : a grant was taken this cycle; move the priority pointer
//   gnt        : one-hot grant (combinational)
// A lone requester always wins; on contention the pointer wins. After a
// grant the pointer moves to the requester that lost.
module rr_arb_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 1'b0;
        else if (adv && (gnt != 2'b00))
            ptr_q <= gnt[0];
    end
endmodule

// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: arbitrates two requesters onto one serial deterministic
// stochastic multiplier and returns the exact product.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : request/result bus (slave side)
//   mul_a/b   : latched operands to the datapath
//   mul_en    : datapath enable, high only while contributions can occur
//   mul_rst   : datapath reset (active high), held while idle or done
//   mul_z     : datapath output counter
//   busy      : high whenever an operation is outstanding
module dsc_mul_sched
    import dsc_pkg::*;
#(
    parameter int SNG_WIDTH = SNG_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    dsc_mul_sched_if.slave         bus,
    output logic [SNG_WIDTH-1:0]   mul_a,
    output logic [SNG_WIDTH-1:0]   mul_b,
    output logic                   mul_en,
    output logic                   mul_rst,
    input  logic [2*SNG_WIDTH-1:0] mul_z,
    output logic                   busy
);
    localparam int W     = SNG_WIDTH;
    localparam int CNT_W = run_len_w(SNG_WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] run_len_q;
    logic [1:0]       arb_req;
    logic [1:0]       gnt;
    logic             hs;
    logic             hs_id;
    logic [W-1:0]     a_sel;
    logic [W-1:0]     b_sel;
    logic             zero_op;
    logic [2*W-1:0]   res_z_q;
    logic             res_id_q;
    logic             res_valid_q;

    // Requests are only visible to the arbiter in IDLE and out of reset, so
    // req_ready is 0 during reset and while an operation is outstanding.
    assign arb_req = (state_q == ST_IDLE && rst) ? bus.req_valid : 2'b00;

    rr_arb_2 u_arb (
        .clk   (clk),
        .rst_n (rst),
        .req   (arb_req),
        .adv   (hs),
        .gnt   (gnt)
    );

    assign bus.req_ready = gnt;
    assign hs            = |gnt;          // a grant is always to a valid requester
    assign hs_id         = gnt[1];
    assign a_sel         = bus.req_a[hs_id*W +: W];
    assign b_sel         = bus.req_b[hs_id*W +: W];
    assign zero_op       = (a_sel == '0) || (b_sel == '0);

    assign bus.res_z     = res_z_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (hs) state_d = zero_op ? ST_DONE : ST_RUN;
            // cnt_q counts RUN cycles from 0, so the last one is run_len-1
            ST_RUN:     if (cnt_q == run_len_q - CNT_W'(1)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    if (bus.res_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_len_q   <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_en      <= 1'b0;
            mul_rst     <= 1'b1;
            busy        <= 1'b0;
            res_z_q     <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_en      <= (state_d == ST_RUN);
            mul_rst     <= (state_d == ST_IDLE) || (state_d == ST_DONE);
            busy        <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);

            if (state_q == ST_IDLE && hs) begin
                mul_a     <= a_sel;
                mul_b     <= b_sel;
                res_id_q  <= hs_id;
                // B stream is 1 only for the first b rows of 2^W cycles
                run_len_q <= CNT_W'(b_sel) << W;
                cnt_q     <= '0;
                res_z_q   <= '0;   // final value for zero operands
            end

            if (state_q == ST_RUN)
                cnt_q <= cnt_q + CNT_W'(1);

            // mul_z has absorbed the last enabled cycle by now
            if (state_q == ST_CAPTURE)
                res_z_q <= mul_z;
        end
    end
endmodule

// File: tb/tb_dsc_mul_sched.sv
// Bench for dsc_mul_sched: a behavioural datapath (counts A&B stream
// coincidences), a transaction-level model of the scheduler (outstanding
// flag, priority bit, product = a*b, latency from run length) compared
// every cycle, plus literal expectations for the directed cases.
module tb_dsc_mul_sched;
    import dsc_pkg::*;

    localparam int W = SNG_WIDTH_DEFAULT;
    localparam int N = 1 << W;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_en, mul_rst, busy;
    logic [2*W-1:0] mul_z;
    logic [2*W-1:0] dp_z;
    int             dp_k;
    int             cyc = 0;

    dsc_mul_sched_if #(.W(W)) bus ();

    dsc_mul_sched #(.SNG_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_en  (mul_en),
        .mul_rst (mul_rst),
        .mul_z   (mul_z),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Deterministic datapath: A stream is 1 for the first a cycles of each
    // 2^W row, B stream is 1 for the first b rows.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_z <= '0;
            dp_k <= 0;
        end else if (mul_rst) begin
            dp_z <= '0;
            dp_k <= 0;
        end else if (mul_en) begin
            if ((dp_k % N) < int'(mul_a) && (dp_k / N) < int'(mul_b))
                dp_z <= dp_z + 1'b1;
            dp_k <= dp_k + 1;
        end
    end
    assign mul_z = dp_z;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int z; int id; int lat; int en; } lit_t;
    lit_t lit [16];
    int   lit_n  = 0;
    int   lit_idx = 0;
    bit   ending = 1'b0;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic id; int hs_cyc; int lat; int len; } op_t;

    // ---------------- compare process ----------------
    initial begin
        op_t        cur;
        bit         m_out = 1'b0;
        bit         m_ptr = 1'b0;
        bit         rose  = 1'b1;
        int         en_cnt = 0;
        logic [1:0] exp_rdy, hs;
        cur = '{a: '0, b: '0, id: 1'b0, hs_cyc: 0, lat: 0, len: 0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_mul_rst",   mul_rst, 1);
                chk("rst_mul_en",    mul_en, 0);
                chk("rst_res_valid", bus.res_valid, 0);
                chk("rst_res_z",     bus.res_z, 0);
                chk("rst_res_id",    bus.res_id, 0);
                chk("rst_mul_a",     mul_a, 0);
                chk("rst_mul_b",     mul_b, 0);
                chk("rst_busy",      busy, 0);
                m_out = 1'b0; m_ptr = 1'b0; rose = 1'b1; en_cnt = 0;
            end else begin
                exp_rdy = 2'b00;
                if (!m_out)
                    exp_rdy = (bus.req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : bus.req_valid;
                chk("req_ready", bus.req_ready, exp_rdy);
                chk("busy", busy, m_out);
                if (mul_en) en_cnt++;
                if (!m_out) begin
                    chk("idle_mul_en", mul_en, 0);
                    chk("idle_mul_rst", mul_rst, 1);
                    chk("idle_res_valid", bus.res_valid, 0);
                end else begin
                    chk("mul_a", mul_a, cur.a);
                    chk("mul_b", mul_b, cur.b);
                    if (bus.res_valid) begin
                        if (!rose) begin
                            rose = 1'b1;
                            chk("latency", cyc - cur.hs_cyc, cur.lat);
                            chk("en_cycles", en_cnt, cur.len);
                            if (lit_idx < lit_n) begin
                                chk("lit_res_z",   bus.res_z, lit[lit_idx].z);
                                chk("lit_res_id",  bus.res_id, lit[lit_idx].id);
                                chk("lit_latency", cyc - cur.hs_cyc, lit[lit_idx].lat);
                                chk("lit_en",      en_cnt, lit[lit_idx].en);
                                lit_idx++;
                            end
                        end
                        chk("res_z", bus.res_z, int'(cur.a) * int'(cur.b));
                        chk("res_id", bus.res_id, cur.id);
                        chk("done_mul_en", mul_en, 0);
                        chk("done_mul_rst", mul_rst, 1);
                        if (bus.res_ready) m_out = 1'b0;
                    end else if (!rose && (cyc - cur.hs_cyc) > cur.lat) begin
                        chk("res_valid_timeout", 0, 1);
                        rose = 1'b1;
                    end
                end
                hs = bus.req_valid & bus.req_ready;
                if (hs != 2'b00) begin
                    cur.id     = hs[1];
                    cur.a      = hs[1] ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
                    cur.b      = hs[1] ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
                    cur.len    = (cur.a == '0 || cur.b == '0) ? 0 : int'(cur.b) * N;
                    cur.lat    = (cur.len == 0) ? 1 : cur.len + 2;
                    cur.hs_cyc = cyc;
                    m_out  = 1'b1;
                    m_ptr  = ~hs[1];
                    en_cnt = 0;
                    rose   = 1'b0;
                end
            end
            if (ending) chk("lits_consumed", lit_idx, lit_n);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
    endtask

    task automatic add_lit(input int z, input int id, input int lat, input int en);
        lit[lit_n] = '{z: z, id: id, lat: lat, en: en};
        lit_n++;
    endtask

    // Present one request, drop it once granted, accept its result.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got  = 1'b0;
        bit done = 1'b0;
        set_op(id, a, b);
        bus.req_valid     = 2'b00;
        bus.req_valid[id] = 1'b1;
        bus.res_ready     = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (got && bus.res_valid) done = 1'b1;
            if (bus.req_valid[id] && bus.req_ready[id]) got = 1'b1;
            @(posedge clk); #1;
            if (got) bus.req_valid[id] = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.req_valid = 2'b00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int  nres;
        bit  got;
        logic [1:0] g;
        rst           = 1'b0;
        bus.req_valid = 2'b11;     // req_ready must still read 0 in reset
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;

        add_lit(15, 0, 50, 48);    run_op(0, 4'd5, 4'd3);
        add_lit(225, 0, 242, 240); run_op(0, 4'd15, 4'd15);
        add_lit(0, 0, 1, 0);       run_op(0, 4'd7, 4'd0);
        add_lit(0, 1, 1, 0);       run_op(1, 4'd0, 4'd9);

        // Both requesters held valid: results alternate starting with r0.
        do_reset();
        add_lit(6, 0, 50, 48); add_lit(20, 1, 82, 80);
        add_lit(6, 0, 50, 48); add_lit(20, 1, 82, 80);
        set_op(0, 4'd2, 4'd3); set_op(1, 4'd4, 4'd5);
        bus.res_ready = 1'b1;
        bus.req_valid = 2'b11;
        nres = 0;
        for (int i = 0; i < 1000 && nres < 4; i++) begin
            @(negedge clk);
            if (bus.res_valid) nres++;
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;

        // Result stalled in DONE for 10 cycles while r0 waits.
        add_lit(12, 1, 66, 64); add_lit(1, 0, 18, 16);
        set_op(1, 4'd3, 4'd4); set_op(0, 4'd1, 4'd1);
        bus.res_ready = 1'b0;
        bus.req_valid = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = bus.req_ready[1];
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); got = bus.res_valid;
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        run_op(0, 4'd1, 4'd1);

        // Reset in the middle of RUN: result discarded, next op clean.
        set_op(0, 4'd9, 4'd6);
        bus.req_valid = 2'b01;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = bus.req_ready[0];
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        repeat (19) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        add_lit(42, 0, 114, 112); run_op(0, 4'd6, 4'd7);

        // Random traffic: arrivals, withdrawals, result back-pressure.
        bus.res_ready = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk); g = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i])
                    bus.req_valid[i] = 1'b0;
                else if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_op(i, W'($urandom_range(0, N-1)), W'($urandom_range(0, 9)));
                        bus.req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 29) == 0)
                    bus.req_valid[i] = 1'b0;
            end
            bus.res_ready = 1'($urandom_range(0, 1));
        end
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1 ending = 1'b1;
        @(negedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
